qspi_mem_arbiter: RTL



---
 rtl/qspi_mem_arbiter_if.sv | 49 ++++
 rtl/qspi_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_arbiter_if.sv
// Bus bundle between the core-side Wishbone-classic requesters, the
// arbiter and the single QSPI XIP memory controller.
//   slave  : arbiter view (requests in, memory side out)
//   master : environment view (requesters plus memory controller)
interface qspi_mem_arbiter_if #(
   parameter int NUM_REQ = 6,
   parameter int AW      = 24,
   parameter int DW      = 32
);
   // Requester side
   logic [NUM_REQ-1:0]      en_i;
   logic [NUM_REQ-1:0]      req_cyc_i;
   logic [NUM_REQ-1:0]      req_we_i;
   logic [NUM_REQ*AW-1:0]   req_adr_i;
   logic [NUM_REQ*DW-1:0]   req_dat_i;
   logic [NUM_REQ*4-1:0]    req_sel_i;
   logic [NUM_REQ-1:0]      req_ack_o;
   logic [NUM_REQ-1:0]      req_err_o;
   logic [DW-1:0]           req_dat_o;

   // Memory controller side
   logic                    mem_cyc_o;
   logic                    mem_we_o;
   logic [AW-1:0]           mem_adr_o;
   logic [DW-1:0]           mem_dat_o;
   logic [3:0]              mem_sel_o;
   logic                    mem_ack_i;
   logic [DW-1:0]           mem_dat_i;

   // Status
   logic [NUM_REQ-1:0]      grant_o;
   logic                    busy_o;

   modport slave (
      input  en_i, req_cyc_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
      input  mem_ack_i, mem_dat_i,
      output req_ack_o, req_err_o, req_dat_o,
      output mem_cyc_o, mem_we_o, mem_adr_o, mem_dat_o, mem_sel_o,
      output grant_o, busy_o
   );

   modport master (
      output en_i, req_cyc_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
      output mem_ack_i, mem_dat_i,
      input  req_ack_o, req_err_o, req_dat_o,
      input  mem_cyc_o, mem_we_o, mem_adr_o, mem_dat_o, mem_sel_o,
      input  grant_o, busy_o
   );
endinterface

// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter sharing one QSPI XIP memory controller between
// NUM_REQ Wishbone-classic masters. A grant covers exactly one bus
// transaction and is always followed by one IDLE cycle.
//
// Optional feature: define QSPI_MEM_ARBITER_TIMEOUT_EN to add an ack
// watchdog that errors out a grant after TIMEOUT BUSY cycles without ack.
module qspi_mem_arbiter #(
   parameter int NUM_REQ = 6,
   parameter int AW      = 24,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk_i,
   input  logic               rst_i,
   qspi_mem_arbiter_if.slave  bus
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  w_grant_nxt;
   logic [IW-1:0]       r_gidx;
   logic [IW-1:0]       w_gidx_nxt;
   logic [IW-1:0]       r_last;
   logic [IW-1:0]       w_last_nxt;

   logic [NUM_REQ-1:0]  w_elig;
   logic                w_found;
   logic [IW-1:0]       w_pick;
   logic                w_cyc_g;
   logic                w_timeout;

   logic                w_mem_cyc;
   logic                w_mem_we;
   logic [AW-1:0]       w_mem_adr;
   logic [DW-1:0]       w_mem_dat;
   logic [3:0]          w_mem_sel;
   logic [NUM_REQ-1:0]  w_req_ack;
   logic [NUM_REQ-1:0]  w_req_err;

`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;
`endif

   // Index of requester base+off, wrapping at NUM_REQ.
   function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IW'(s);
   endfunction

   // Disabled requesters never compete.
   assign w_elig  = bus.req_cyc_i & bus.en_i;
   assign w_cyc_g = bus.req_cyc_i[r_gidx];

`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
   // r_cnt counts completed ack-less BUSY cycles, so the TIMEOUT-th BUSY
   // cycle is the one where it holds TIMEOUT-1. Ack in that cycle wins.
   assign w_timeout = (r_state == S_BUSY) && !bus.mem_ack_i &&
                      (r_cnt == CW'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;

   // TIMEOUT only matters when the watchdog is compiled in.
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
`endif

   // Round-robin search: first eligible requester after the last one served.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && w_elig[f_wrap(r_last, k)]) begin
            w_found = 1'b1;
            w_pick  = f_wrap(r_last, k);
         end
      end
   end

   // State register: grant, its index, round-robin pointer and watchdog.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values, independent of statement order.
      if (rst_i) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(NUM_REQ - 1);
`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_gidx  <= w_gidx_nxt;
         r_last  <= w_last_nxt;
`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
         r_cnt   <= w_cnt_nxt;
`endif
      end
   end

   // Next state: grant from IDLE, release on ack, abort or timeout.
   always_comb begin
      // NOTE: hold-value defaults on every path keep this block free of latches.
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_last_nxt  = r_last;
`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_BUSY;
               w_grant_nxt = NUM_REQ'(1) << w_pick;
               w_gidx_nxt  = w_pick;
`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
               w_cnt_nxt   = '0;
`endif
            end
         end
         S_BUSY: begin
            if (bus.mem_ack_i || !w_cyc_g || w_timeout) begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
               w_last_nxt  = r_gidx;
            end else begin
`ifdef QSPI_MEM_ARBITER_TIMEOUT_EN
               w_cnt_nxt   = r_cnt + CW'(1);
`endif
            end
         end
      endcase
   end

   // Outputs: route the granted requester to memory, fan ack/err back out.
   always_comb begin
      w_mem_cyc = 1'b0;
      w_mem_we  = 1'b0;
      w_mem_adr = '0;
      w_mem_dat = '0;
      w_mem_sel = '0;
      w_req_ack = '0;
      w_req_err = '0;
      if (r_state == S_BUSY) begin
         // cyc follows the requester so an abort reaches memory the same cycle.
         w_mem_cyc = w_cyc_g && !w_timeout;
         w_mem_we  = bus.req_we_i[r_gidx];
         w_mem_adr = bus.req_adr_i[r_gidx*AW +: AW];
         w_mem_dat = bus.req_dat_i[r_gidx*DW +: DW];
         w_mem_sel = bus.req_sel_i[r_gidx*4 +: 4];
         if (bus.mem_ack_i) w_req_ack = r_grant;
         if (w_timeout)     w_req_err = r_grant;
      end
   end

   assign bus.mem_cyc_o = w_mem_cyc;
   assign bus.mem_we_o  = w_mem_we;
   assign bus.mem_adr_o = w_mem_adr;
   assign bus.mem_dat_o = w_mem_dat;
   assign bus.mem_sel_o = w_mem_sel;
   assign bus.req_ack_o = w_req_ack;
   assign bus.req_err_o = w_req_err;
   assign bus.req_dat_o = bus.mem_dat_i;
   assign bus.grant_o   = r_grant;
   assign bus.busy_o    = (r_state == S_BUSY);

endmodule
